led_bank_arbiter: RTL and testbench

Shares the 7-pin LED/GPIO bank (io_out[14:8], io_oeb[14:8]) between several requesters, typically the RISC-V core's LED port and a host/debug master. Round-robin arbitration with request/grant handshake, a registered output stage, and a one-cycle tri-state turnaround on every ownership change. Sits between `riscv_top`'s `led_out`/`io_oeb` and the pad ring inside the user wrapper.

---
 rtl/led_bank_arbiter.sv | 153 +++++++++++++++
 tb/tb_led_bank_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin owner arbitration of the 7-pin LED/GPIO bank with a safe one-cycle
// tri-state turnaround on every ownership change. Define LED_ARB_TIMEOUT_EN for tenure revocation.
module led_bank_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ*WIDTH-1:0]   req_oeb,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        led_out,
  output logic [WIDTH-1:0]        io_oeb,
  output logic                    busy,
  output logic                    timeout
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN     = 2'd1,
    S_HANDOFF = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d, win;
  logic             found;
  logic [NREQ-1:0]  eligible, owner_oh, gnt_d;
  logic [WIDTH-1:0] own_data, own_oeb, led_d, oeb_d;
  logic             owner_req, revoke, busy_d, timeout_d;

  // Owner is always the last winner; extract its slices.
  assign owner_oh  = NREQ'(1) << last_q;
  assign owner_req = |(req & owner_oh);

  always_comb begin
    own_data = '0;
    own_oeb  = '1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (last_q == IDX_W'(i)) begin
        own_data = req_data[i*WIDTH +: WIDTH];
        own_oeb  = req_oeb[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef LED_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic [NREQ-1:0]  mask_q, mask_d;

  assign eligible = req & ~mask_q;
  assign revoke   = ((32'(hold_cnt_q) + 32'd1) >= MAX_HOLD) && (|(req & ~owner_oh));
  // A revoked owner stays masked until it is seen with req low.
  assign mask_d   = (mask_q & req) | (timeout_d ? owner_oh : '0);

  // Tenure counter: zero outside OWN, so it is clear on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_q <= '0;
      mask_q     <= '0;
    end else begin
      mask_q <= mask_d;
      if (state_q != S_OWN) begin
        hold_cnt_q <= '0;
      end else if (hold_cnt_q != '1) begin
        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  logic unused_hold;

  assign eligible    = req;
  assign revoke      = 1'b0;
  assign unused_hold = &{1'b0, MAX_HOLD, CNT_W};
`endif

  // Round-robin search starting just above the previous winner.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    win      = last_q;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_q) + k) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = '0;
    led_d     = '0;
    oeb_d     = '1;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_OWN;
          last_d  = win;
          gnt_d   = NREQ'(1) << win;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          state_d = S_HANDOFF;
        end else if (revoke) begin
          state_d   = S_HANDOFF;
          timeout_d = 1'b1;
        end else begin
          gnt_d = owner_oh;
          led_d = own_data;
          oeb_d = own_oeb;
        end
      end
      S_HANDOFF: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(NREQ - 1);
      gnt     <= '0;
      led_out <= '0;
      io_oeb  <= '1;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      led_out <= led_d;
      io_oeb  <= oeb_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter (NREQ=2, WIDTH=7, MAX_HOLD=4); follows LED_ARB_TIMEOUT_EN.
module tb_led_bank_arbiter;

  typedef struct packed {
    logic [1:0] gnt;
    logic [6:0] led;
    logic [6:0] oeb;
    logic       busy;
    logic       to;
  } exp_t;

  typedef struct packed {
    logic [1:0] req;
    logic [6:0] d0, o0, d1, o1;
    exp_t       e;
  } row_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [13:0] req_data;
  logic [13:0] req_oeb;
  logic [1:0]  gnt;
  logic [6:0]  led_out;
  logic [6:0]  io_oeb;
  logic        busy;
  logic        timeout;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  led_bank_arbiter #(.NREQ(2), .WIDTH(7), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_oeb(req_oeb),
    .gnt(gnt), .led_out(led_out), .io_oeb(io_oeb), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(input logic [1:0] rq, input logic [6:0] d0, o0, d1, o1,
                              input logic [1:0] g, input logic [6:0] l, ob,
                              input logic b, t);
    row_t r;
    r.req = rq; r.d0 = d0; r.o0 = o0; r.d1 = d1; r.o1 = o1;
    r.e.gnt = g; r.e.led = l; r.e.oeb = ob; r.e.busy = b; r.e.to = t;
    return r;
  endfunction

  task automatic test_reset;
    exp_t want;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req      = 2'($urandom);
      req_data = 14'($urandom);
      req_oeb  = 14'($urandom);
      exp_q.push_back(exp_t'{2'b00, 7'h00, 7'h7F, 1'b0, 1'b0});
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if ({gnt, led_out, io_oeb, busy, timeout} !== want) begin
        failures++;
        $display("FAIL reset[%0d]: gnt=%b led=%h oeb=%h busy=%b to=%b need gnt=%b led=%h oeb=%h busy=%b to=%b",
                 i, gnt, led_out, io_oeb, busy, timeout, want.gnt, want.led, want.oeb, want.busy, want.to);
      end
    end
    req = 2'b00; req_data = '0; req_oeb = '0;
    reset = 1'b1;
  endtask

  task automatic test_single_owner;
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(2'b01, 7'h55, 7'h00, 7'h7F, 7'h00, 2'b01, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b01, 7'h55, 7'h00, 7'h7F, 7'h00, 2'b01, 7'h55, 7'h00, 1, 0));
    rows.push_back(mk(2'b01, 7'h2A, 7'h00, 7'h7F, 7'h00, 2'b01, 7'h2A, 7'h00, 1, 0));
    rows.push_back(mk(2'b01, 7'h2A, 7'h15, 7'h7F, 7'h00, 2'b01, 7'h2A, 7'h15, 1, 0));
    rows.push_back(mk(2'b00, 7'h2A, 7'h15, 7'h7F, 7'h00, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b00, 7'h2A, 7'h15, 7'h7F, 7'h00, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b01, 7'h2A, 7'h15, 7'h7F, 7'h00, 2'b01, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b01, 7'h2A, 7'h15, 7'h7F, 7'h00, 2'b01, 7'h2A, 7'h15, 1, 0));
    foreach (rows[i]) begin
      req = rows[i].req; req_data = {rows[i].d1, rows[i].d0}; req_oeb = {rows[i].o1, rows[i].o0};
      exp_q.push_back(rows[i].e);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if ({gnt, led_out, io_oeb, busy, timeout} !== want) begin
        failures++;
        $display("FAIL single[%0d]: gnt=%b led=%h oeb=%h busy=%b to=%b need gnt=%b led=%h oeb=%h busy=%b to=%b",
                 i, gnt, led_out, io_oeb, busy, timeout, want.gnt, want.led, want.oeb, want.busy, want.to);
      end
    end
    // Asynchronous reset mid-OWN must act before the next clock edge.
    #2 reset = 1'b0;
    exp_q.push_back(exp_t'{2'b00, 7'h00, 7'h7F, 1'b0, 1'b0});
    #1;
    want = exp_q.pop_front();
    checks++;
    if ({gnt, led_out, io_oeb, busy, timeout} !== want) begin
      failures++;
      $display("FAIL async_reset: gnt=%b led=%h oeb=%h busy=%b to=%b need gnt=%b led=%h oeb=%h busy=%b to=%b",
               gnt, led_out, io_oeb, busy, timeout, want.gnt, want.led, want.oeb, want.busy, want.to);
    end
    req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_round_robin;
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(2'b11, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b01, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b11, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b01, 7'h11, 7'h00, 1, 0));
    rows.push_back(mk(2'b11, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b01, 7'h11, 7'h00, 1, 0));
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b10, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b10, 7'h22, 7'h0F, 1, 0));
    rows.push_back(mk(2'b01, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b01, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b01, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b01, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b01, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b01, 7'h11, 7'h00, 1, 0));
    foreach (rows[i]) begin
      req = rows[i].req; req_data = {rows[i].d1, rows[i].d0}; req_oeb = {rows[i].o1, rows[i].o0};
      exp_q.push_back(rows[i].e);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if ({gnt, led_out, io_oeb, busy, timeout} !== want) begin
        failures++;
        $display("FAIL rr[%0d]: gnt=%b led=%h oeb=%h busy=%b to=%b need gnt=%b led=%h oeb=%h busy=%b to=%b",
                 i, gnt, led_out, io_oeb, busy, timeout, want.gnt, want.led, want.oeb, want.busy, want.to);
      end
    end
  endtask

  task automatic test_simultaneous;
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b10, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b10, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b10, 7'h22, 7'h0F, 1, 0));
    rows.push_back(mk(2'b01, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b01, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b01, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b01, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b00, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b00, 7'h11, 7'h00, 7'h22, 7'h0F, 2'b00, 7'h00, 7'h7F, 0, 0));
    foreach (rows[i]) begin
      req = rows[i].req; req_data = {rows[i].d1, rows[i].d0}; req_oeb = {rows[i].o1, rows[i].o0};
      exp_q.push_back(rows[i].e);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if ({gnt, led_out, io_oeb, busy, timeout} !== want) begin
        failures++;
        $display("FAIL simul[%0d]: gnt=%b led=%h oeb=%h busy=%b to=%b need gnt=%b led=%h oeb=%h busy=%b to=%b",
                 i, gnt, led_out, io_oeb, busy, timeout, want.gnt, want.led, want.oeb, want.busy, want.to);
      end
    end
    // A request that rises and falls between edges is never sampled.
    req = 2'b10;
    exp_q.push_back(exp_t'{2'b00, 7'h00, 7'h7F, 1'b0, 1'b0});
    #3 req = 2'b00;
    @(posedge clk); #1;
    want = exp_q.pop_front();
    checks++;
    if ({gnt, led_out, io_oeb, busy, timeout} !== want) begin
      failures++;
      $display("FAIL glitch: gnt=%b led=%h oeb=%h busy=%b to=%b need gnt=%b led=%h oeb=%h busy=%b to=%b",
               gnt, led_out, io_oeb, busy, timeout, want.gnt, want.led, want.oeb, want.busy, want.to);
    end
  endtask

  task automatic test_timeout;
    row_t rows[$];
    exp_t want;
    rows.push_back(mk(2'b01, 7'h33, 7'h01, 7'h44, 7'h02, 2'b01, 7'h00, 7'h7F, 1, 0));
`ifdef LED_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(2'b11, 7'h33, 7'h01, 7'h44, 7'h02, 2'b01, 7'h33, 7'h01, 1, 0));
    rows.push_back(mk(2'b11, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 1, 1));
    rows.push_back(mk(2'b11, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b11, 7'h33, 7'h01, 7'h44, 7'h02, 2'b10, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b11, 7'h33, 7'h01, 7'h44, 7'h02, 2'b10, 7'h44, 7'h02, 1, 0));
    rows.push_back(mk(2'b01, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 1, 0));
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(2'b01, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b00, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b01, 7'h33, 7'h01, 7'h44, 7'h02, 2'b01, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b01, 7'h33, 7'h01, 7'h44, 7'h02, 2'b01, 7'h33, 7'h01, 1, 0));
    rows.push_back(mk(2'b00, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b00, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 0, 0));
`else
    for (int i = 0; i < 1000; i++)
      rows.push_back(mk(2'b11, 7'h33, 7'h01, 7'h44, 7'h02, 2'b01, 7'h33, 7'h01, 1, 0));
    rows.push_back(mk(2'b10, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b10, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 0, 0));
    rows.push_back(mk(2'b10, 7'h33, 7'h01, 7'h44, 7'h02, 2'b10, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b00, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 1, 0));
    rows.push_back(mk(2'b00, 7'h33, 7'h01, 7'h44, 7'h02, 2'b00, 7'h00, 7'h7F, 0, 0));
`endif
    foreach (rows[i]) begin
      req = rows[i].req; req_data = {rows[i].d1, rows[i].d0}; req_oeb = {rows[i].o1, rows[i].o0};
      exp_q.push_back(rows[i].e);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++;
      if ({gnt, led_out, io_oeb, busy, timeout} !== want) begin
        failures++;
        $display("FAIL timeout[%0d]: gnt=%b led=%h oeb=%h busy=%b to=%b need gnt=%b led=%h oeb=%h busy=%b to=%b",
                 i, gnt, led_out, io_oeb, busy, timeout, want.gnt, want.led, want.oeb, want.busy, want.to);
      end
    end
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; req_data = '0; req_oeb = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_simultaneous();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
